// File: rtl/bp_axil_wr_arbiter.sv
// Two-master AXI-Lite write arbiter with in-order B routing via a grant-ID FIFO.
// Define BP_AXIL_ARB_FIXED_PRIO_EN for fixed priority (s0 wins); default is round-robin.
module bp_axil_wr_arbiter #(
    parameter int addr_width_p      = 32,
    parameter int data_width_p      = 32,
    parameter int max_outstanding_p = 8
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [1:0][addr_width_p-1:0]             s_axil_awaddr_i,
    input  logic [1:0][2:0]                          s_axil_awprot_i,
    input  logic [1:0]                               s_axil_awvalid_i,
    output logic [1:0]                               s_axil_awready_o,
    input  logic [1:0][data_width_p-1:0]             s_axil_wdata_i,
    input  logic [1:0][data_width_p/8-1:0]           s_axil_wstrb_i,
    input  logic [1:0]                               s_axil_wvalid_i,
    output logic [1:0]                               s_axil_wready_o,
    output logic [1:0][1:0]                          s_axil_bresp_o,
    output logic [1:0]                               s_axil_bvalid_o,
    input  logic [1:0]                               s_axil_bready_i,
    output logic [addr_width_p-1:0]                  m_axil_awaddr_o,
    output logic [2:0]                               m_axil_awprot_o,
    output logic                                     m_axil_awvalid_o,
    input  logic                                     m_axil_awready_i,
    output logic [data_width_p-1:0]                  m_axil_wdata_o,
    output logic [data_width_p/8-1:0]                m_axil_wstrb_o,
    output logic                                     m_axil_wvalid_o,
    input  logic                                     m_axil_wready_i,
    input  logic [1:0]                               m_axil_bresp_i,
    input  logic                                     m_axil_bvalid_i,
    output logic                                     m_axil_bready_o,
    output logic                                     busy_o,
    output logic [$clog2(max_outstanding_p+1)-1:0]   outstanding_o,
    output logic                                     err_o
);

    localparam int cnt_w = $clog2(max_outstanding_p + 1);
    localparam int ptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    typedef enum logic {e_idle, e_xfer} state_e;

    state_e                       r_state, w_state_next;
    logic                         r_grant, r_aw_done, r_w_done, r_err;
    logic [max_outstanding_p-1:0] r_ids;
    logic [ptr_w-1:0]             r_wptr, r_rptr;
    logic [cnt_w-1:0]             r_count;
`ifndef BP_AXIL_ARB_FIXED_PRIO_EN
    logic                         r_rr;
`endif

    logic w_grant_fire, w_winner, w_can_grant, w_aw_hs, w_w_hs, w_complete;
    logic w_empty, w_head, w_pop;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(max_outstanding_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_can_grant = (r_count < cnt_w'(max_outstanding_p));
    assign w_empty     = (r_count == '0);
    assign w_head      = r_ids[r_rptr];

`ifdef BP_AXIL_ARB_FIXED_PRIO_EN
    assign w_winner = ~s_axil_awvalid_i[0];
`else
    assign w_winner = (&s_axil_awvalid_i) ? r_rr : s_axil_awvalid_i[1];
`endif

    // Arbitration FSM and AW/W pass-through; non-granted master always sees ready = 0.
    always_comb begin
        w_state_next     = r_state;
        w_grant_fire     = 1'b0;
        w_aw_hs          = 1'b0;
        w_w_hs           = 1'b0;
        w_complete       = 1'b0;
        m_axil_awvalid_o = 1'b0;
        m_axil_wvalid_o  = 1'b0;
        s_axil_awready_o = '0;
        s_axil_wready_o  = '0;
        m_axil_awaddr_o  = s_axil_awaddr_i[r_grant];
        m_axil_awprot_o  = s_axil_awprot_i[r_grant];
        m_axil_wdata_o   = s_axil_wdata_i[r_grant];
        m_axil_wstrb_o   = s_axil_wstrb_i[r_grant];
        case (r_state)
            e_idle: begin
                if ((|s_axil_awvalid_i) && w_can_grant) begin
                    w_grant_fire = 1'b1;
                    w_state_next = e_xfer;
                end
            end
            e_xfer: begin
                m_axil_awvalid_o          = s_axil_awvalid_i[r_grant] & ~r_aw_done;
                m_axil_wvalid_o           = s_axil_wvalid_i[r_grant] & ~r_w_done;
                s_axil_awready_o[r_grant] = m_axil_awready_i & ~r_aw_done;
                s_axil_wready_o[r_grant]  = m_axil_wready_i & ~r_w_done;
                w_aw_hs = m_axil_awvalid_o & m_axil_awready_i;
                w_w_hs  = m_axil_wvalid_o & m_axil_wready_i;
                if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
                    w_complete   = 1'b1;
                    w_state_next = e_idle;
                end
            end
            default: w_state_next = e_idle;
        endcase
    end

    // B routing from the FIFO head; an empty FIFO sinks stray responses.
    always_comb begin
        s_axil_bvalid_o = '0;
        if (!w_empty) s_axil_bvalid_o[w_head] = m_axil_bvalid_i;
        m_axil_bready_o = w_empty ? 1'b1 : s_axil_bready_i[w_head];
        s_axil_bresp_o  = {2{m_axil_bresp_i}};
    end

    assign w_pop         = m_axil_bvalid_i & m_axil_bready_o & ~w_empty;
    assign busy_o        = (r_state == e_xfer) | ~w_empty;
    assign outstanding_o = r_count;
    assign err_o         = r_err;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state   <= e_idle;
            r_grant   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
`ifndef BP_AXIL_ARB_FIXED_PRIO_EN
            r_rr      <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_grant_fire) begin
                r_grant   <= w_winner;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
            if (w_complete) begin
                r_wptr <= ptr_inc(r_wptr);
`ifndef BP_AXIL_ARB_FIXED_PRIO_EN
                r_rr   <= ~r_grant;
`endif
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);
            r_count <= r_count + cnt_w'(w_complete) - cnt_w'(w_pop);
            if (m_axil_bvalid_i && w_empty) r_err <= 1'b1;
        end
    end

    // ID storage is data only; validity is tracked by r_count.
    always_ff @(posedge clk_i) begin
        if (w_complete) r_ids[r_wptr] <= r_grant;
    end

endmodule

// File: tb/tb_bp_axil_wr_arbiter.sv
// Directed self-checking bench for bp_axil_wr_arbiter (default parameters).
module tb_bp_axil_wr_arbiter;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0][31:0] s_awaddr;
    logic [1:0][2:0]  s_awprot;
    logic [1:0]       s_awvalid, s_awready;
    logic [1:0][31:0] s_wdata;
    logic [1:0][3:0]  s_wstrb;
    logic [1:0]       s_wvalid, s_wready;
    logic [1:0][1:0]  s_bresp;
    logic [1:0]       s_bvalid, s_bready;
    logic [31:0]      m_awaddr;
    logic [2:0]       m_awprot;
    logic             m_awvalid, m_awready;
    logic [31:0]      m_wdata;
    logic [3:0]       m_wstrb;
    logic             m_wvalid, m_wready;
    logic [1:0]       m_bresp;
    logic             m_bvalid, m_bready;
    logic             busy, err;
    logic [3:0]       outstanding;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_axil_wr_arbiter dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .s_axil_awaddr_i(s_awaddr), .s_axil_awprot_i(s_awprot),
        .s_axil_awvalid_i(s_awvalid), .s_axil_awready_o(s_awready),
        .s_axil_wdata_i(s_wdata), .s_axil_wstrb_i(s_wstrb),
        .s_axil_wvalid_i(s_wvalid), .s_axil_wready_o(s_wready),
        .s_axil_bresp_o(s_bresp), .s_axil_bvalid_o(s_bvalid), .s_axil_bready_i(s_bready),
        .m_axil_awaddr_o(m_awaddr), .m_axil_awprot_o(m_awprot),
        .m_axil_awvalid_o(m_awvalid), .m_axil_awready_i(m_awready),
        .m_axil_wdata_o(m_wdata), .m_axil_wstrb_o(m_wstrb),
        .m_axil_wvalid_o(m_wvalid), .m_axil_wready_i(m_wready),
        .m_axil_bresp_i(m_bresp), .m_axil_bvalid_i(m_bvalid), .m_axil_bready_o(m_bready),
        .busy_o(busy), .outstanding_o(outstanding), .err_o(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic single_write(input int k, input logic [31:0] a, input logic [31:0] d);
        bit got;
        got = 1'b0;
        @(negedge clk);
        s_awvalid[k] = 1'b1; s_wvalid[k] = 1'b1;
        s_awaddr[k] = a; s_wdata[k] = d; s_wstrb[k] = 4'hF;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk); #1;
            if (s_awready[k] && s_wready[k]) begin
                got = 1'b1;
                chk("wr_addr", m_awaddr, a);
            end
        end
        chk("wr_handshake", got, 1);
        @(posedge clk);
        @(negedge clk);
        s_awvalid[k] = 1'b0; s_wvalid[k] = 1'b0;
    endtask

    initial begin
        int cnt [2];
        int glog [8];
        int ng;
        int exp_k;

        reset_n = 1'b0;
        s_awaddr = '0; s_awprot = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0;
        s_wvalid = '0; s_bready = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_bresp = 2'b00; m_bvalid = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_awvalid", m_awvalid, 0);
        chk("rst_m_wvalid", m_wvalid, 0);
        chk("rst_s_awready", s_awready, 0);
        chk("rst_s_wready", s_wready, 0);
        chk("rst_s_bvalid", s_bvalid, 0);
        chk("rst_m_bready", m_bready, 1);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        reset_n = 1'b1;

        // Contention: both masters request continuously for 4 writes each
        cnt[0] = 0; cnt[1] = 0; ng = 0;
        for (int cyc = 0; cyc < 40 && ng < 8; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                s_awvalid[k] = (cnt[k] < 4);
                s_wvalid[k]  = (cnt[k] < 4);
                s_awaddr[k]  = 32'h1000_0000 * (k + 1) + cnt[k];
                s_wdata[k]   = 32'hA000_0000 + k * 16 + cnt[k];
                s_wstrb[k]   = 4'hF;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                if (s_awready[k] && s_wready[k]) begin
                    chk("cont_addr", m_awaddr, 32'h1000_0000 * (k + 1) + cnt[k]);
                    glog[ng] = k;
                    ng++;
                    cnt[k]++;
                end
            end
        end
        chk("cont_grants", ng, 8);
        @(negedge clk);
        s_awvalid = '0; s_wvalid = '0;
        #1;
        chk("cont_outstanding", outstanding, 8);
        for (int i = 0; i < 8; i++) begin
`ifdef BP_AXIL_ARB_FIXED_PRIO_EN
            exp_k = (i < 4) ? 0 : 1;
`else
            exp_k = i % 2;
`endif
            chk("cont_order", glog[i], exp_k);
        end
        s_bready = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m_bvalid = 1'b1;
            #1;
`ifdef BP_AXIL_ARB_FIXED_PRIO_EN
            exp_k = (i < 4) ? 0 : 1;
`else
            exp_k = i % 2;
`endif
            chk("cont_b_route", s_bvalid, 2'b01 << exp_k);
        end
        @(negedge clk);
        m_bvalid = 1'b0;
        #1;
        chk("cont_drained", outstanding, 0);

        // Single write from s0, AW and W together
        @(negedge clk);
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1;
        s_awaddr[0] = 32'h8000_0000; s_wdata[0] = 32'hDEAD_BEEF; s_wstrb[0] = 4'hF;
        #1;
        chk("sw_idle_awvalid", m_awvalid, 0);
        @(negedge clk); #1;
        chk("sw_awvalid", m_awvalid, 1);
        chk("sw_wvalid", m_wvalid, 1);
        chk("sw_awaddr", m_awaddr, 32'h8000_0000);
        chk("sw_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("sw_wstrb", m_wstrb, 4'hF);
        chk("sw_s_awready", s_awready, 2'b01);
        chk("sw_s_wready", s_wready, 2'b01);
        @(negedge clk);
        s_awvalid = '0; s_wvalid = '0;
        #1;
        chk("sw_outstanding", outstanding, 1);
        chk("sw_busy", busy, 1);
        chk("sw_after_awvalid", m_awvalid, 0);
        m_bvalid = 1'b1; m_bresp = 2'b00;
        #1;
        chk("sw_b_route", s_bvalid, 2'b01);
        chk("sw_bresp", s_bresp[0], 2'b00);
        chk("sw_m_bready", m_bready, 1);
        @(negedge clk);
        m_bvalid = 1'b0;
        #1;
        chk("sw_outstanding_end", outstanding, 0);
        chk("sw_busy_end", busy, 0);

        // Split channels: W held off for 5 cycles after AW accepts
        m_wready = 1'b0;
        @(negedge clk);
        s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1;
        s_awaddr[1] = 32'h0000_0040; s_wdata[1] = 32'h1234_5678; s_wstrb[1] = 4'h3;
        @(negedge clk); #1;
        chk("split_awready", s_awready, 2'b10);
        chk("split_wready_low", s_wready, 2'b00);
        @(negedge clk);
        s_awvalid[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("split_no_second_aw", m_awvalid, 0);
            chk("split_locked_awready", s_awready, 0);
            chk("split_pending", outstanding, 0);
        end
        @(negedge clk);
        m_wready = 1'b1;
        #1;
        chk("split_wready", s_wready, 2'b10);
        chk("split_wstrb", m_wstrb, 4'h3);
        @(negedge clk);
        s_wvalid[1] = 1'b0;
        #1;
        chk("split_complete", outstanding, 1);
        m_bvalid = 1'b1;
        #1;
        chk("split_b_route", s_bvalid, 2'b10);
        @(negedge clk);
        m_bvalid = 1'b0;
        #1;
        chk("split_drained", outstanding, 0);

        // Backpressure: B withheld, FIFO fills at 8
        s_bready = 2'b00;
        for (int i = 0; i < 8; i++) single_write(0, 32'h2000_0000 + i, i);
        #1;
        chk("bp_full", outstanding, 8);
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_awaddr[0] = 32'h2000_0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("bp_no_grant_awready", s_awready, 0);
            chk("bp_no_grant_awvalid", m_awvalid, 0);
            chk("bp_stuck_count", outstanding, 8);
        end
        @(negedge clk);
        m_bvalid = 1'b1; s_bready = 2'b01;
        #1;
        chk("bp_release_route", s_bvalid, 2'b01);
        @(negedge clk);
        m_bvalid = 1'b0; s_bready = 2'b00;
        #1;
        chk("bp_after_pop", outstanding, 7);
        chk("bp_idle_awready", s_awready, 0);
        @(negedge clk); #1;
        chk("bp_ninth_awready", s_awready, 2'b01);
        chk("bp_ninth_addr", m_awaddr, 32'h2000_0100);
        @(negedge clk);
        s_awvalid = '0; s_wvalid = '0;
        #1;
        chk("bp_full_again", outstanding, 8);
        m_bvalid = 1'b1; s_bready = 2'b11;
        for (int i = 0; i < 12 && outstanding != 0; i++) @(negedge clk);
        m_bvalid = 1'b0;
        #1;
        chk("bp_drained", outstanding, 0);
        chk("bp_no_err", err, 0);

        // Stray B with FIFO empty
        @(negedge clk);
        m_bvalid = 1'b1; s_bready = 2'b00;
        #1;
        chk("stray_m_bready", m_bready, 1);
        chk("stray_s_bvalid", s_bvalid, 0);
        @(negedge clk);
        m_bvalid = 1'b0;
        #1;
        chk("stray_err", err, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("stray_err_sticky", err, 1);

        // Reset after AW accepted but before W
        m_wready = 1'b0;
        @(negedge clk);
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_awaddr[0] = 32'h3000_0000;
        @(negedge clk); #1;
        chk("rx_awready", s_awready, 2'b01);
        @(negedge clk);
        s_awvalid[0] = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        s_wvalid[0] = 1'b0;
        m_wready = 1'b1;
        #1;
        chk("rx_m_awvalid", m_awvalid, 0);
        chk("rx_m_wvalid", m_wvalid, 0);
        chk("rx_s_wready", s_wready, 0);
        chk("rx_busy", busy, 0);
        chk("rx_outstanding", outstanding, 0);
        chk("rx_err_cleared", err, 0);
        chk("rx_m_bready", m_bready, 1);
        m_bvalid = 1'b1;
        #1;
        chk("rx_late_b_sbvalid", s_bvalid, 0);
        @(negedge clk);
        m_bvalid = 1'b0;
        #1;
        chk("rx_late_b_err", err, 1);
        single_write(1, 32'h4000_0000, 32'h5555_AAAA);
        #1;
        chk("rx_new_write", outstanding, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
